awmc_drum_plant: RTL and testbench
==================================

// Module: awmc_drum_plant
// PURPOSE
//  Machine-side responder for the washing-machine controller. Consumes the controller's
//  stage/input_valve/output_drain commands and models drum water level, motor speed ramp
//  and lid interlock. Returns lid status and level sensors for closed-loop simulation/FPGA demo.
//  Sits between the controller outputs and its lid input; all plant dynamics advance on a prescaled tick.
// PARAMETERS
//  LEVEL_W      8    width of water_level
//  LEVEL_MAX    200  full-drum level (must be < 2**LEVEL_W)
//  FILL_STEP    4    level increment per tick while filling
//  DRAIN_STEP   5    level decrement per tick while draining
//  TICK_DIV     4    clk cycles per plant tick (>=1)
//  SPEED_W      4    width of motor_speed
//  WASH_SPEED   6    motor target in WASH
//  RINSE_SPEED  4    motor target in RINSE
//  SPIN_SPEED   15   motor target in SPIN
// PORTS
//  clk           in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-low reset
//  stage         in   3        controller stage: 000 IDLE, 001 FILL, 010 WASH, 011 RINSE, 100 SPIN, others = IDLE
//  input_valve   in   1        fill command
//  output_drain  in   1        drain command
//  lid_open_req  in   1        user request to open lid (level-sensitive)
//  lid           out  1        1 = lid closed and locked, 0 = open (drives controller lid input)
//  water_level   out  LEVEL_W  current drum level
//  water_full    out  1        water_level == LEVEL_MAX
//  water_empty   out  1        water_level == 0
//  motor_speed   out  SPEED_W  current drum speed
//  motor_on      out  1        motor_speed != 0
//  fault         out  1        sticky plant fault
// BEHAVIOUR
//  Reset (reset==0, async): prescaler=0, water_level=0, motor_speed=0, lid FSM=CLOSED (lid=1), fault=0;
//   hence water_empty=1, water_full=0, motor_on=0. Release is sampled on next clk edge.
//  Tick: prescaler counts 0..TICK_DIV-1; tick is a 1-cycle pulse when count==TICK_DIV-1, then wraps to 0.
//   TICK_DIV=1 -> tick every cycle. Level and speed update only on tick edges.
//  Level (on tick): valve only -> min(level+FILL_STEP, LEVEL_MAX), summed in LEVEL_W+1 bits;
//   drain only -> max(level-DRAIN_STEP, 0), no underflow wrap; both -> hold and set fault; neither -> hold.
//  water_full/water_empty/motor_on: combinational decode of registered state, no extra latency.
//  Motor target: WASH->WASH_SPEED, RINSE->RINSE_SPEED, SPIN->SPIN_SPEED, else 0; forced 0 when lid==0.
//   On tick: speed<target -> +1, speed>target -> -1, equal -> hold. Stage change mid-ramp retargets at next tick.
//  Lid FSM (evaluated every clk, not tick). safe = (motor_speed==0 && water_level==0):
//   CLOSED  (lid=1): req&safe -> OPEN; req&!safe -> PENDING; else stay.
//   PENDING (lid=1): !req -> CLOSED; req&safe -> OPEN; else stay.
//   OPEN    (lid=0): !req -> CLOSED; else stay.
//   lid changes the clk edge after the qualifying condition; never opens while motor turns or water present.
//  Fault (sticky until reset): set on valve&drain at a tick; set at any clk where input_valve==1 with lid==0,
//   or stage in {WASH,RINSE,SPIN} with lid==0. Fault does not freeze plant dynamics.
//  Reset mid-operation: all state returns to reset values immediately regardless of tick phase or lid state.
// TESTING (defaults)
//  1 Fill: stage=001, valve=1 from reset -> level 4 after 4 clks; 200 after 50 ticks (200 clks);
//    water_full=1, holds 200 with valve still high, fault=0.
//  2 Drain: from 200, drain=1 -> 195 after first tick; 0 after 40 ticks; water_empty=1, stays 0 (no wrap).
//  3 Conflict: level 100, valve=drain=1 -> level holds 100, fault=1 at tick; stays 1 after both drop.
//  4 Spin ramp: stage=100, lid closed -> speed 1..15 over 15 ticks, motor_on=1; stage=000 -> 15..0 over 15 ticks.
//  5 Interlock: lid_open_req=1 at speed 8 -> lid stays 1 (PENDING) until speed 0 and level 0, then lid=0
//    one clk later; deassert req -> lid=1 next clk.
//  6 Async reset mid-spin (speed 9, level 120, fault=1): reset=0 between edges -> outputs at reset values
//    immediately; after release, prescaler restarts, first tick 4 clks later.

Source files
------------

// File: rtl/awmc_drum_plant.sv
`default_nettype none
// ============================================================================
//  Module   : awmc_drum_plant
//  Purpose  : Drum plant model for the washing-machine controller. It tracks
//             water level, motor speed ramp and the lid interlock.
//  Revision : 1.0 - initial release
// ============================================================================
module awmc_drum_plant #(
  parameter int LEVEL_W     = 8,
  parameter int LEVEL_MAX   = 200,
  parameter int FILL_STEP   = 4,
  parameter int DRAIN_STEP  = 5,
  parameter int TICK_DIV    = 4,
  parameter int SPEED_W     = 4,
  parameter int WASH_SPEED  = 6,
  parameter int RINSE_SPEED = 4,
  parameter int SPIN_SPEED  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         stage,
  input  logic               input_valve,
  input  logic               output_drain,
  input  logic               lid_open_req,
  output logic               lid,
  output logic [LEVEL_W-1:0] water_level,
  output logic               water_full,
  output logic               water_empty,
  output logic [SPEED_W-1:0] motor_speed,
  output logic               motor_on,
  output logic               fault
);

  localparam int                 c_PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
  localparam logic [LEVEL_W-1:0] c_LEVEL_MAX  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W:0]   c_FILL_STEP  = (LEVEL_W+1)'(FILL_STEP);
  localparam logic [LEVEL_W-1:0] c_DRAIN_STEP = LEVEL_W'(DRAIN_STEP);
  localparam logic [SPEED_W-1:0] c_WASH_SPD   = SPEED_W'(WASH_SPEED);
  localparam logic [SPEED_W-1:0] c_RINSE_SPD  = SPEED_W'(RINSE_SPEED);
  localparam logic [SPEED_W-1:0] c_SPIN_SPD   = SPEED_W'(SPIN_SPEED);

  localparam logic [2:0] c_STAGE_WASH  = 3'b010;
  localparam logic [2:0] c_STAGE_RINSE = 3'b011;
  localparam logic [2:0] c_STAGE_SPIN  = 3'b100;

  typedef enum logic [1:0] {
    LID_CLOSED  = 2'd0,
    LID_PENDING = 2'd1,
    LID_OPEN    = 2'd2
  } lid_state_t;

  logic [c_PRESC_W-1:0] r_presc;
  logic [LEVEL_W-1:0]   r_level;
  logic [SPEED_W-1:0]   r_speed;
  logic                 r_fault;
  lid_state_t           r_lid_state;
  lid_state_t           w_lid_next;

  logic                 w_tick;
  logic [LEVEL_W:0]     w_fill_sum;
  logic [LEVEL_W-1:0]   w_level_fill;
  logic [LEVEL_W-1:0]   w_level_drain;
  logic [LEVEL_W-1:0]   w_level_next;
  logic [SPEED_W-1:0]   w_target;
  logic [SPEED_W-1:0]   w_speed_next;
  logic                 w_stage_run;
  logic                 w_conflict;
  logic                 w_safe;
  logic                 w_fault_set;

  // ---------------------------------------------------------------- prescaler
  assign w_tick = (r_presc == c_PRESC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // -------------------------------------------------------------- water level
  // Fill sum carries an extra bit so saturation works even near 2**LEVEL_W.
  assign w_fill_sum    = {1'b0, r_level} + c_FILL_STEP;
  assign w_level_fill  = (w_fill_sum > {1'b0, c_LEVEL_MAX}) ? c_LEVEL_MAX : w_fill_sum[LEVEL_W-1:0];
  assign w_level_drain = (r_level < c_DRAIN_STEP) ? '0 : (r_level - c_DRAIN_STEP);
  assign w_conflict    = input_valve & output_drain;

  always_comb begin
    w_level_next = r_level;
    if (input_valve && !output_drain) begin
      w_level_next = w_level_fill;
    end else if (output_drain && !input_valve) begin
      w_level_next = w_level_drain;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
    end else if (w_tick) begin
      r_level <= w_level_next;
    end
  end

  // -------------------------------------------------------------- motor ramp
  assign w_stage_run = (stage == c_STAGE_WASH) || (stage == c_STAGE_RINSE) ||
                       (stage == c_STAGE_SPIN);

  always_comb begin
    w_target = '0;
    if (lid) begin
      case (stage)
        c_STAGE_WASH:  w_target = c_WASH_SPD;
        c_STAGE_RINSE: w_target = c_RINSE_SPD;
        c_STAGE_SPIN:  w_target = c_SPIN_SPD;
        default:       w_target = '0;
      endcase
    end
  end

  always_comb begin
    w_speed_next = r_speed;
    if (r_speed < w_target) begin
      w_speed_next = r_speed + 1'b1;
    end else if (r_speed > w_target) begin
      w_speed_next = r_speed - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_speed <= '0;
    end else if (w_tick) begin
      r_speed <= w_speed_next;
    end
  end

  // ---------------------------------------------------------- lid interlock
  assign w_safe = (r_speed == '0) && (r_level == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lid_state <= LID_CLOSED;
    end else begin
      r_lid_state <= w_lid_next;
    end
  end

  always_comb begin
    w_lid_next = r_lid_state;
    case (r_lid_state)
      LID_CLOSED: begin
        if (lid_open_req) begin
          w_lid_next = w_safe ? LID_OPEN : LID_PENDING;
        end
      end
      LID_PENDING: begin
        if (!lid_open_req) begin
          w_lid_next = LID_CLOSED;
        end else if (w_safe) begin
          w_lid_next = LID_OPEN;
        end
      end
      LID_OPEN: begin
        if (!lid_open_req) begin
          w_lid_next = LID_CLOSED;
        end
      end
      default: w_lid_next = LID_CLOSED;
    endcase
  end

  // ------------------------------------------------------------ sticky fault
  // Lid-related misuse is checked every clk; the valve/drain conflict only at a tick.
  assign w_fault_set = (w_tick & w_conflict) | (input_valve & ~lid) | (w_stage_run & ~lid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign lid         = (r_lid_state != LID_OPEN);
  assign water_level = r_level;
  assign water_full  = (r_level == c_LEVEL_MAX);
  assign water_empty = (r_level == '0);
  assign motor_speed = r_speed;
  assign motor_on    = (r_speed != '0);
  assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_awmc_drum_plant.sv
`default_nettype none
// ============================================================================
//  Module   : tb_awmc_drum_plant
//  Purpose  : Directed self-checking bench for awmc_drum_plant (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_awmc_drum_plant;

  logic       clk;
  logic       reset;
  logic [2:0] stage;
  logic       input_valve;
  logic       output_drain;
  logic       lid_open_req;
  logic       lid;
  logic [7:0] water_level;
  logic       water_full;
  logic       water_empty;
  logic [3:0] motor_speed;
  logic       motor_on;
  logic       fault;

  int r_checks;
  int r_failures;

  awmc_drum_plant u_dut (
    .clk          (clk),
    .reset        (reset),
    .stage        (stage),
    .input_valve  (input_valve),
    .output_drain (output_drain),
    .lid_open_req (lid_open_req),
    .lid          (lid),
    .water_level  (water_level),
    .water_full   (water_full),
    .water_empty  (water_empty),
    .motor_speed  (motor_speed),
    .motor_on     (motor_on),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    r_checks++;
    if (actual !== expected) begin
      r_failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance n clk edges; inputs are driven and outputs sampled on negedges.
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    r_checks     = 0;
    r_failures   = 0;
    reset        = 1'b0;
    stage        = 3'b000;
    input_valve  = 1'b0;
    output_drain = 1'b0;
    lid_open_req = 1'b0;

    // Reset state
    clks(2);
    check("rst_level", water_level, 0);
    check("rst_empty", water_empty, 1);
    check("rst_full",  water_full,  0);
    check("rst_speed", motor_speed, 0);
    check("rst_motor_on", motor_on, 0);
    check("rst_lid",   lid,   1);
    check("rst_fault", fault, 0);

    // Fill from empty: first tick on the 4th edge after release
    reset = 1'b1; stage = 3'b001; input_valve = 1'b1;
    clks(3);
    check("fill_pre_tick", water_level, 0);
    clks(1);
    check("fill_first_tick", water_level, 4);
    clks(196);
    check("fill_full_level", water_level, 200);
    check("fill_full_flag", water_full, 1);
    clks(4);
    check("fill_saturate", water_level, 200);
    check("fill_no_fault", fault, 0);

    // Drain to empty with no wrap
    input_valve = 1'b0; output_drain = 1'b1; stage = 3'b000;
    clks(4);
    check("drain_first_tick", water_level, 195);
    check("drain_not_full", water_full, 0);
    clks(156);
    check("drain_empty_level", water_level, 0);
    check("drain_empty_flag", water_empty, 1);
    clks(4);
    check("drain_no_wrap", water_level, 0);

    // Conflict: valve and drain together
    output_drain = 1'b0; input_valve = 1'b1;
    clks(100);
    check("conf_level_100", water_level, 100);
    output_drain = 1'b1;
    clks(3);
    check("conf_fault_before_tick", fault, 0);
    clks(1);
    check("conf_hold_level", water_level, 100);
    check("conf_fault_set", fault, 1);
    input_valve = 1'b0; output_drain = 1'b0;
    clks(4);
    check("conf_fault_sticky", fault, 1);

    // Spin ramp up and down
    stage = 3'b100;
    clks(4);
    check("spin_first", motor_speed, 1);
    check("spin_motor_on", motor_on, 1);
    clks(56);
    check("spin_top", motor_speed, 15);
    clks(4);
    check("spin_hold_top", motor_speed, 15);
    stage = 3'b000;
    clks(4);
    check("spin_down_first", motor_speed, 14);
    clks(56);
    check("spin_down_zero", motor_speed, 0);
    check("spin_motor_off", motor_on, 0);

    // Interlock: request at speed 8 with water still in the drum
    stage = 3'b100;
    clks(32);
    check("lock_speed8", motor_speed, 8);
    lid_open_req = 1'b1;
    clks(1);
    check("lock_pending", lid, 1);
    stage = 3'b000; output_drain = 1'b1;
    clks(79);
    check("lock_level_zero", water_level, 0);
    check("lock_speed_zero", motor_speed, 0);
    check("lock_still_closed", lid, 1);
    clks(1);
    check("lock_opened", lid, 0);
    output_drain = 1'b0; lid_open_req = 1'b0;
    clks(1);
    check("lock_reclosed", lid, 1);
    clks(2);

    // Build up speed 9, level 120, fault 1, then reset between edges
    input_valve = 1'b1;
    clks(120);
    check("pre_rst_level", water_level, 120);
    input_valve = 1'b0; stage = 3'b100;
    clks(36);
    check("pre_rst_speed", motor_speed, 9);
    check("pre_rst_fault", fault, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_level", water_level, 0);
    check("arst_speed", motor_speed, 0);
    check("arst_fault", fault, 0);
    check("arst_lid",   lid, 1);
    check("arst_empty", water_empty, 1);
    stage = 3'b001; input_valve = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    clks(3);
    check("arst_pre_tick", water_level, 0);
    clks(1);
    check("arst_first_tick", water_level, 4);

    // Lid open while running a wash stage raises the fault
    reset = 1'b0;
    input_valve = 1'b0; stage = 3'b000;
    clks(1);
    reset = 1'b1;
    lid_open_req = 1'b1;
    clks(1);
    check("open_when_safe", lid, 0);
    check("open_no_fault", fault, 0);
    stage = 3'b010;
    clks(1);
    check("open_wash_fault", fault, 1);
    clks(4);
    check("open_no_motor", motor_speed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
    $finish;
  end

endmodule
`default_nettype wire
